// File: rtl/step_sequencer_if.sv
// Control/pattern-write inputs and voice-trigger outputs of the drum step sequencer.
// With SEQ_SWING_EN defined the bundle also carries swing_on.
interface step_sequencer_if #(
  parameter int unsigned STEPS  = 16,
  parameter int unsigned TICK_W = 24
);
  localparam int unsigned SW = $clog2(STEPS);

  logic              run;
  logic [TICK_W-1:0] tempo;
`ifdef SEQ_SWING_EN
  logic              swing_on;
`endif
  logic              pat_we;
  logic [1:0]        pat_track;
  logic [SW-1:0]     pat_step;
  logic              pat_bit;
  logic              go;
  logic [2:0]        sel;
  logic              en;
  logic [SW-1:0]     step;

  modport master (
    output run, tempo,
`ifdef SEQ_SWING_EN
    output swing_on,
`endif
    output pat_we, pat_track, pat_step, pat_bit,
    input  go, sel, en, step
  );

  modport slave (
    input  run, tempo,
`ifdef SEQ_SWING_EN
    input  swing_on,
`endif
    input  pat_we, pat_track, pat_step, pat_bit,
    output go, sel, en, step
  );
endinterface

// File: rtl/step_sequencer.sv
// 4-track x STEPS-step drum sequencer: fires one voice per step into a monophonic player.
// Optional feature: define SEQ_SWING_EN to add swing_on (long/short alternating step pairs).
module step_sequencer #(
  parameter int unsigned STEPS  = 16,
  parameter int unsigned TICK_W = 24
) (
  input  logic       clk_i,
  input  logic       reset_i,
  step_sequencer_if.slave bus_io
);
  localparam int unsigned SW = $clog2(STEPS);
`ifdef SEQ_SWING_EN
  localparam int unsigned CW = TICK_W + 1;
`else
  localparam int unsigned CW = TICK_W;
`endif

  logic [3:0]    pat_q [STEPS];
  logic [CW-1:0] tick_q, tick_d, period_end;
  logic [SW-1:0] step_q, step_d, fire_step;
  logic [1:0]    sel_q, sel_d;
  logic          armed_q, armed_d, go_q, go_d, en_q;
  logic          fire;
  logic [3:0]    column;

`ifdef SEQ_SWING_EN
  logic [CW-1:0] tempo_x, quarter;

  // Even-indexed steps are stretched and odd ones shrunk by the same quarter period.
  always_comb begin
    tempo_x = {1'b0, bus_io.tempo};
    quarter = (tempo_x + CW'(1)) >> 2;
    if (!bus_io.swing_on) begin
      period_end = tempo_x;
    end else if (!step_q[0]) begin
      period_end = tempo_x + quarter;
    end else begin
      period_end = tempo_x - quarter;
    end
  end
`else
  assign period_end = bus_io.tempo;
`endif

  assign fire      = bus_io.run & (armed_q | (tick_q >= period_end));
  assign fire_step = armed_q ? '0 : step_q + SW'(1);
  assign column    = pat_q[fire_step];

  always_comb begin
    tick_d  = tick_q + CW'(1);
    step_d  = step_q;
    armed_d = armed_q;
    go_d    = 1'b0;
    sel_d   = sel_q;
    if (!bus_io.run) begin
      tick_d  = '0;
      step_d  = '0;
      armed_d = 1'b1;
    end else if (fire) begin
      tick_d  = '0;
      step_d  = fire_step;
      armed_d = 1'b0;
      if (|column) begin
        go_d = 1'b1;
        // Lowest track wins: kick > snare > hat > clap.
        if (column[0]) begin
          sel_d = 2'd0;
        end else if (column[1]) begin
          sel_d = 2'd1;
        end else if (column[2]) begin
          sel_d = 2'd2;
        end else begin
          sel_d = 2'd3;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tick_q  <= '0;
      step_q  <= '0;
      armed_q <= 1'b0;
      go_q    <= 1'b0;
      sel_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      step_q  <= step_d;
      armed_q <= armed_d;
      go_q    <= go_d;
      sel_q   <= sel_d;
      en_q    <= bus_io.run;
    end
  end

  // Fire reads pat_q before this edge, so a same-cycle write shows up on the next pass.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < STEPS; s++) begin
        pat_q[s] <= '0;
      end
    end else if (bus_io.pat_we) begin
      pat_q[bus_io.pat_step][bus_io.pat_track] <= bus_io.pat_bit;
    end
  end

  assign bus_io.go   = go_q;
  assign bus_io.sel  = {1'b0, sel_q};
  assign bus_io.en   = en_q;
  assign bus_io.step = step_q;
endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a fire-schedule reference model predicts every cycle's
// go/sel/step/en; a monitor pops and compares one prediction per clock.
module tb_step_sequencer;
  localparam int unsigned STEPS  = 16;
  localparam int unsigned TICK_W = 24;
  localparam int unsigned SW     = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  step_sequencer_if #(.STEPS(STEPS), .TICK_W(TICK_W)) bus ();

  step_sequencer #(.STEPS(STEPS), .TICK_W(TICK_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          go;
    logic [2:0]    sel;
    logic [SW-1:0] step;
    logic          en;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: pattern array plus the edge number of the last fired step.
  bit m_pat [4][STEPS];
  bit m_running = 1'b0;
  int m_edge = 0;
  int m_last = 0;
  int m_step = 0;
  int m_sel  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("go", int'(bus.go), int'(e.go));
      check("sel", int'(bus.sel), int'(e.sel));
      check("step", int'(bus.step), int'(e.step));
      check("en", int'(bus.en), int'(e.en));
    end
  end

  // Drive one cycle of inputs and push what the model says the outputs become at the next edge.
  task automatic drive(input bit rst, input bit run, input int tempo, input bit sw,
                       input bit we, input int trk, input int stp, input bit b);
    exp_t e;
    bit   fire;
    bit   found;
    int   nstep;
    int   per;
    @(negedge clk);
    reset         = rst;
    bus.run       = run;
    bus.tempo     = TICK_W'(tempo);
`ifdef SEQ_SWING_EN
    bus.swing_on  = sw;
`endif
    bus.pat_we    = we;
    bus.pat_track = 2'(trk);
    bus.pat_step  = SW'(stp);
    bus.pat_bit   = b;
    m_edge++;
    e     = '0;
    fire  = 1'b0;
    nstep = 0;
    if (rst) begin
      for (int t = 0; t < 4; t++)
        for (int s = 0; s < STEPS; s++) m_pat[t][s] = 1'b0;
      m_running = 1'b0;
      m_step    = 0;
      m_sel     = 0;
    end else begin
      per = tempo + 1;
`ifdef SEQ_SWING_EN
      if (sw) per = (m_step % 2 == 0) ? per + per / 4 : per - per / 4;
`endif
      if (!run) begin
        m_running = 1'b0;
        m_step    = 0;
      end else if (!m_running) begin
        m_running = 1'b1;
        fire      = 1'b1;
        nstep     = 0;
      end else if (m_edge - m_last >= per) begin
        fire  = 1'b1;
        nstep = (m_step + 1) % STEPS;
      end
      if (fire) begin
        m_last = m_edge;
        m_step = nstep;
        found  = 1'b0;
        for (int t = 0; t < 4; t++) begin
          if (!found && m_pat[t][nstep]) begin
            found = 1'b1;
            m_sel = t;
          end
        end
        e.go = found;
      end
      if (we) m_pat[trk][stp] = b;
      e.sel  = 3'(m_sel);
      e.step = SW'(m_step);
      e.en   = run;
    end
    exp_q.push_back(e);
  endtask

  task automatic play(input int n, input bit run, input int tempo, input bit sw);
    for (int i = 0; i < n; i++) drive(1'b0, run, tempo, sw, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int trk, input int stp, input bit b);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, trk, stp, b);
  endtask

  initial begin
    bus.run       = 1'b0;
    bus.tempo     = '0;
`ifdef SEQ_SWING_EN
    bus.swing_on  = 1'b0;
`endif
    bus.pat_we    = 1'b0;
    bus.pat_track = '0;
    bus.pat_step  = '0;
    bus.pat_bit   = 1'b0;

    // Reset, then idle.
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    play(2, 1'b0, 0, 1'b0);

    // Four-on-the-floor kick, tempo 3, past the bar wrap.
    for (int s = 0; s < 16; s += 4) wr(0, s, 1'b1);
    play(70, 1'b1, 3, 1'b0);
    play(1, 1'b0, 3, 1'b0);

    // Priority on step 2; empty steps hold sel.
    wr(0, 2, 1'b1);
    wr(2, 2, 1'b1);
    wr(3, 2, 1'b1);
    wr(1, 1, 1'b1);
    wr(2, 6, 1'b1);
    play(20, 1'b1, 0, 1'b0);
    play(1, 1'b0, 0, 1'b0);

    // Snare written on step 5 in the cycle step 5 fires.
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 1'b1, 0, 1'b0, i == 5, 1, 5, 1'b1);
    end
    play(1, 1'b0, 0, 1'b0);

    // Tempo lowered mid-step, then run dropped mid-step.
    play(8, 1'b1, 9, 1'b0);
    play(10, 1'b1, 2, 1'b0);
    play(3, 1'b0, 2, 1'b0);

`ifdef SEQ_SWING_EN
    for (int s = 0; s < 16; s++) wr(0, s, 1'b1);
    play(40, 1'b1, 7, 1'b1);
    play(1, 1'b0, 7, 1'b1);
    play(40, 1'b1, 7, 1'b0);
    play(1, 1'b0, 7, 1'b0);
`endif

    // Asynchronous reset while playing.
    play(7, 1'b1, 1, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_go", int'(bus.go), 0);
    check("async_sel", int'(bus.sel), 0);
    check("async_step", int'(bus.step), 0);
    check("async_en", int'(bus.en), 0);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    play(2, 1'b0, 0, 1'b0);
    play(20, 1'b1, 0, 1'b0);
    play(1, 1'b0, 0, 1'b0);

    // Randomized play with writes, tempo changes and run toggles.
    begin
      bit r_run   = 1'b1;
      int r_tempo = 2;
      bit r_sw    = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 39) == 0) r_run = ~r_run;
        if ($urandom_range(0, 29) == 0) r_tempo = $urandom_range(0, 5);
        if ($urandom_range(0, 49) == 0) r_sw = ~r_sw;
        drive(1'b0, r_run, r_tempo, r_sw, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, STEPS - 1), 1'($urandom_range(0, 1)));
      end
    end
    play(2, 1'b0, 0, 1'b0);

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
